// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: widths, op codes, FSM states.
package muldiv_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned CNT_W      = $clog2(DATA_WIDTH);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Magnitude of a two's-complement value; passes raw bits through for unsigned ops.
  function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] x,
                                                    input logic is_signed);
    return (is_signed && x[DATA_WIDTH-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// 2W-bit accumulator/remainder shift register with one shift-add multiply or
// restoring-divide step per cycle, operating on unsigned magnitudes.
module muldiv_datapath #(
  parameter int unsigned W = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_load,
  input  logic           i_step,
  input  logic           i_is_div,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_acc
);

  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_b;
  logic [W:0]     w_sum;
  logic [W:0]     w_diff;
  logic           w_fits;
  logic [2*W-1:0] w_next;

  // Multiply: add into upper half then shift right. Divide: shift left, trial-subtract divisor.
  // A set top bit before the shift means the shifted remainder exceeds any W-bit divisor.
  always_comb begin
    w_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_diff = {1'b0, r_acc[2*W-2:W-1]} - {1'b0, r_b};
    w_fits = r_acc[2*W-1] | ~w_diff[W];
    w_next = {w_sum, r_acc[W-1:1]};
    if (i_is_div) begin
      if (w_fits) w_next = {w_diff[W-1:0], r_acc[W-2:0], 1'b1};
      else        w_next = {r_acc[2*W-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_acc <= {{W{1'b0}}, i_a};
      r_b   <= i_b;
    end else if (i_step) begin
      r_acc <= w_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the architectural HI/LO
// registers; stalls the pipeline while an operation is in flight.
module hilo_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [2:0]            Op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  ReadHiLo,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivByZero,
  output logic                  Stall,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int unsigned W = DATA_WIDTH;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_res_neg;
  logic             r_rem_neg;
  logic             r_b_zero;
  logic [W-1:0]     r_a_raw;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic             w_op_signed;
  logic             w_op_div;
  logic             w_op_arith;
  logic             w_load;
  logic             w_step;
  logic [W-1:0]     w_a_mag;
  logic [W-1:0]     w_b_mag;
  logic [2*W-1:0]   w_acc;
  logic [2*W-1:0]   w_prod;
  logic [W-1:0]     w_quo;
  logic [W-1:0]     w_rem;
  logic [W-1:0]     w_fix_hi;
  logic [W-1:0]     w_fix_lo;

  assign w_op_signed = (Op == OP_MULT) || (Op == OP_DIV);
  assign w_op_div    = (Op == OP_DIV)  || (Op == OP_DIVU);
  assign w_op_arith  = (Op == OP_MULT) || (Op == OP_MULTU) || w_op_div;
  assign w_load      = (r_state == IDLE) && Start && w_op_arith;
  assign w_step      = (r_state == RUN);
  assign w_a_mag     = abs_val(A, w_op_signed);
  assign w_b_mag     = abs_val(B, w_op_signed);

  muldiv_datapath #(.W(W)) u_datapath (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_is_div (r_is_div),
    .i_a      (w_a_mag),
    .i_b      (w_b_mag),
    .o_acc    (w_acc)
  );

  // Sign fix-up of the unsigned result; divide by zero bypasses the datapath result.
  always_comb begin
    w_prod   = r_res_neg ? -w_acc : w_acc;
    w_quo    = r_res_neg ? -w_acc[W-1:0] : w_acc[W-1:0];
    w_rem    = r_rem_neg ? -w_acc[2*W-1:W] : w_acc[2*W-1:W];
    w_fix_hi = w_prod[2*W-1:W];
    w_fix_lo = w_prod[W-1:0];
    if (r_is_div) begin
      if (r_b_zero) begin
        w_fix_hi = r_a_raw;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = w_rem;
        w_fix_lo = w_quo;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_res_neg <= 1'b0;
      r_rem_neg <= 1'b0;
      r_b_zero  <= 1'b0;
      r_a_raw   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (Start) begin
            if (w_op_arith) begin
              r_state   <= RUN;
              r_busy    <= 1'b1;
              r_cnt     <= CNT_W'(W - 1);
              r_is_div  <= w_op_div;
              r_res_neg <= w_op_signed & (A[W-1] ^ B[W-1]);
              r_rem_neg <= w_op_signed & A[W-1];
              r_b_zero  <= w_op_div & (B == '0);
              r_a_raw   <= A;
            end else if (Op == OP_MTHI) begin
              r_hi <= A;
            end else if (Op == OP_MTLO) begin
              r_lo <= A;
            end
          end
        end
        RUN: begin
          if (r_cnt == '0) r_state <= FIX;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end
        FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_dbz   <= r_b_zero;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign DivByZero = r_dbz;
  assign HI        = r_hi;
  assign LO        = r_lo;
  assign Stall     = r_busy & (Start | ReadHiLo);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed scenarios plus randomized
// operations checked against an arithmetic HI/LO reference model.
module tb_hilo_muldiv_unit;
  import muldiv_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = OP_NONE;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        ReadHiLo = 1'b0;
  logic        Busy, Done, DivByZero, Stall;
  logic [31:0] HI, LO;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dbz = 1'b0;

  hilo_muldiv_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .ReadHiLo(ReadHiLo), .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
    .Stall(Stall), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Architectural effect of one accepted operation, from plain integer arithmetic.
  function automatic void ref_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, q, r;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_dbz = 1'b0;
    case (op)
      OP_MULT: begin
        sp = sa * sb;
        m_hi = sp[63:32]; m_lo = sp[31:0];
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          m_lo = '1; m_hi = a; m_dbz = 1'b1;
        end else if (op == OP_DIV) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; Op = OP_NONE;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (Busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    n_tests++;
    if ({Busy, Done, DivByZero, Stall} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {Busy, Done, DivByZero, Stall});
    end
    n_tests++;
    if ({HI, LO} !== 64'd0) begin
      n_fail++; $display("FAIL reset_hilo: got %h_%h want 0_0", HI, LO);
    end
    Reset = 1'b0;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult_signed();
    int cyc;
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
    wait_idle(cyc);
    n_tests++;
    if (cyc !== 33) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 33", cyc); end
    n_tests++;
    if ({Done, DivByZero} !== 2'b10) begin
      n_fail++; $display("FAIL mult_done: got done/dbz %b want 10", {Done, DivByZero});
    end
    n_tests++;
    if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFA) begin
      n_fail++; $display("FAIL mult_result: got %h_%h want ffffffff_fffffffa", HI, LO);
    end
    @(negedge Clk);
    n_tests++;
    if (Done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b want 0", Done); end
  endtask

  task automatic test_multu_div();
    int cyc;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    wait_idle(cyc);
    n_tests++;
    if ({HI, LO} !== 64'h00000001_FFFFFFFE) begin
      n_fail++; $display("FAIL multu_result: got %h_%h want 00000001_fffffffe", HI, LO);
    end
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(cyc);
    n_tests++;
    if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFD) begin
      n_fail++; $display("FAIL div_neg_result: got %h_%h want ffffffff_fffffffd", HI, LO);
    end
  endtask

  task automatic test_div_by_zero();
    int cyc;
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_idle(cyc);
    n_tests++;
    if (cyc !== 33) begin n_fail++; $display("FAIL dbz_busy_cycles: got %0d want 33", cyc); end
    n_tests++;
    if ({Done, DivByZero} !== 2'b11) begin
      n_fail++; $display("FAIL dbz_pulse: got done/dbz %b want 11", {Done, DivByZero});
    end
    n_tests++;
    if ({HI, LO} !== 64'h00000007_FFFFFFFF) begin
      n_fail++; $display("FAIL dbz_result: got %h_%h want 00000007_ffffffff", HI, LO);
    end
    @(negedge Clk);
    n_tests++;
    if (DivByZero !== 1'b0) begin n_fail++; $display("FAIL dbz_pulse_width: got %b want 0", DivByZero); end
  endtask

  task automatic test_mthi_mtlo_readhilo();
    int cyc;
    int bad;
    issue(OP_MTHI, 32'h1234, 32'd0);
    n_tests++;
    if ({HI, Busy, Done} !== {32'h1234, 2'b00}) begin
      n_fail++; $display("FAIL mthi: got hi=%h busy=%b done=%b want 1234/0/0", HI, Busy, Done);
    end
    issue(OP_MTLO, 32'h5678, 32'd0);
    n_tests++;
    if ({LO, Busy, Done} !== {32'h5678, 2'b00}) begin
      n_fail++; $display("FAIL mtlo: got lo=%h busy=%b done=%b want 5678/0/0", LO, Busy, Done);
    end
    @(negedge Clk);
    ReadHiLo = 1'b1; Start = 1'b1; Op = OP_MULT; A = 32'd4; B = 32'd2;
    #1;
    n_tests++;
    if (Stall !== 1'b0) begin n_fail++; $display("FAIL idle_start_read_stall: got %b want 0", Stall); end
    @(negedge Clk);
    Start = 1'b0; Op = OP_NONE;
    cyc = 0; bad = 0;
    while (Busy === 1'b1 && cyc < 200) begin
      if (Stall !== 1'b1 || HI !== 32'h1234 || LO !== 32'h5678) bad++;
      cyc++;
      @(negedge Clk);
    end
    n_tests++;
    if (bad !== 0 || cyc !== 33) begin
      n_fail++; $display("FAIL read_while_busy: got %0d bad cycles over %0d busy want 0 over 33", bad, cyc);
    end
    n_tests++;
    if ({Done, Stall, HI, LO} !== {2'b10, 32'd0, 32'd8}) begin
      n_fail++; $display("FAIL read_done: got done=%b stall=%b hi=%h lo=%h want 1/0/0/8", Done, Stall, HI, LO);
    end
    ReadHiLo = 1'b0;
  endtask

  task automatic test_busy_ignore();
    int tot;
    int cyc;
    issue(OP_DIV, 32'd100, 32'd7);
    tot = 0;
    repeat (5) begin tot++; @(negedge Clk); end
    Start = 1'b1; Op = OP_MULT; A = 32'h11; B = 32'h3;
    #1;
    n_tests++;
    if (Stall !== 1'b1) begin n_fail++; $display("FAIL start_busy_stall: got %b want 1", Stall); end
    while (Busy === 1'b1 && tot < 200) begin tot++; @(negedge Clk); end
    n_tests++;
    if (tot !== 33 || Done !== 1'b1) begin
      n_fail++; $display("FAIL busy_ignore_latency: got %0d cycles done=%b want 33/1", tot, Done);
    end
    n_tests++;
    if ({HI, LO} !== {32'd2, 32'd14}) begin
      n_fail++; $display("FAIL busy_ignore_div: got %h_%h want 00000002_0000000e", HI, LO);
    end
    @(negedge Clk);
    Start = 1'b0; Op = OP_NONE;
    n_tests++;
    if (Busy !== 1'b1) begin n_fail++; $display("FAIL done_cycle_accept: got busy %b want 1", Busy); end
    wait_idle(cyc);
    n_tests++;
    if (cyc !== 33 || {HI, LO} !== {32'd0, 32'h33}) begin
      n_fail++; $display("FAIL back_to_back_mult: got %0d cycles %h_%h want 33 00000000_00000033", cyc, HI, LO);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int bad;
    issue(OP_MULT, 32'h00012345, 32'h00000777);
    repeat (9) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    n_tests++;
    if ({Busy, HI, LO} !== 65'd0) begin
      n_fail++; $display("FAIL mid_reset: got busy=%b hi=%h lo=%h want 0/0/0", Busy, HI, LO);
    end
    @(negedge Clk);
    Reset = 1'b0;
    m_hi = '0; m_lo = '0;
    bad = 0;
    repeat (40) begin
      @(negedge Clk);
      if (Done !== 1'b0 || Busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL aborted_no_done: got %0d bad cycles want 0", bad); end
    issue(OP_MULTU, 32'd3, 32'd5);
    wait_idle(cyc);
    n_tests++;
    if ({HI, LO} !== {32'd0, 32'd15}) begin
      n_fail++; $display("FAIL post_reset_multu: got %h_%h want 00000000_0000000f", HI, LO);
    end
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    int          cyc;
    ref_exec(OP_MTHI, 32'h0BADF00D, 32'd0); issue(OP_MTHI, 32'h0BADF00D, 32'd0);
    ref_exec(OP_MTLO, 32'h600DCAFE, 32'd0); issue(OP_MTLO, 32'h600DCAFE, 32'd0);
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_val();
      b  = pick_val();
      if (i == 0) begin op = OP_DIV; a = 32'h80000000; b = 32'hFFFFFFFF; end
      ref_exec(op, a, b);
      issue(op, a, b);
      if (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
        wait_idle(cyc);
        n_tests++;
        if (cyc !== 33 || Done !== 1'b1 || DivByZero !== m_dbz) begin
          n_fail++;
          $display("FAIL rand_ctrl[%0d] op=%0d: got cycles=%0d done=%b dbz=%b want 33/1/%b",
                   i, op, cyc, Done, DivByZero, m_dbz);
        end
      end else begin
        n_tests++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
          n_fail++; $display("FAIL rand_nonarith[%0d] op=%0d: got busy=%b done=%b want 0/0", i, op, Busy, Done);
        end
      end
      n_tests++;
      if ({HI, LO} !== {m_hi, m_lo}) begin
        n_fail++;
        $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h: got %h_%h want %h_%h", i, op, a, b, HI, LO, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_multu_div();
    test_div_by_zero();
    test_mthi_mtlo_readhilo();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit that sits beside the EX-stage ALU32Bit and takes the MULT/MULTU/DIV/DIVU/MTHI/MTLO operations the single-cycle ALU cannot finish.
- Receives operands with a start handshake, runs a 32-iteration shift-add multiply or restoring divide, and writes the architectural HI/LO registers.
- Provides HI/LO to the pipeline for MFHI/MFLO, and asserts Stall when a new operation or a HI/LO read would collide with an operation in progress.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. Iteration count equals DATA_WIDTH.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request. Sampled on a rising Clk edge only when Op != NONE.
- Op  input  3  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO. Codes 7 and above behave as NONE.
- A  input  DATA_WIDTH  rs operand. Multiplicand or dividend, and the MTHI/MTLO source.
- B  input  DATA_WIDTH  rt operand. Multiplier or divisor.
- ReadHiLo  input  1  the pipeline is issuing MFHI/MFLO this cycle.
- Busy  output  1  a multiply or divide is in progress.
- Done  output  1  one-cycle pulse when a multiply or divide result has been written to HI/LO.
- DivByZero  output  1  one-cycle pulse coincident with Done when a DIV/DIVU had B == 0.
- Stall  output  1  combinational: Busy & (Start | ReadHiLo).
- HI  output  DATA_WIDTH  HI register.
- LO  output  DATA_WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE.
  - HI, LO, the iteration counter and all working registers clear to 0.
  - Busy, Done and DivByZero clear to 0.
  - An aborted operation never produces Done.
- State machine IDLE -> RUN -> FIX -> IDLE:
  - IDLE: Start with MULT/MULTU/DIV/DIVU latches the absolute values of the operands (MULTU/DIVU use the raw operands), latches the result-sign and remainder-sign flags, loads the counter with DATA_WIDTH-1, and moves to RUN.
  - IDLE: Start with MTHI or MTLO writes A into HI or LO on that edge and stays in IDLE. It does not assert Busy or Done.
  - RUN: one shift-add or restoring-subtract step per cycle. After the step at counter == 0, move to FIX. Otherwise decrement the counter.
  - FIX: apply two's-complement negation per the latched sign flags, write HI/LO on the exiting edge, and go to IDLE.
- Latency:
  - Busy is high in RUN and FIX for exactly DATA_WIDTH+1 cycles, starting the cycle after Start is sampled.
  - Done and DivByZero are registered and high for the single cycle after FIX. New HI/LO values are visible in that same cycle.
- Multiply: the 2*DATA_WIDTH product goes HI = upper half, LO = lower half. MULT is signed, MULTU is unsigned.
- Divide: LO = quotient, HI = remainder.
  - Signed division truncates toward zero.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
- Divide by zero: no trap. LO = all ones, HI = A (unmodified dividend). Latency is the same as a normal divide, and DivByZero pulses with Done.
- Start while Busy: ignored, and Stall is asserted. The pipeline holds the instruction and re-presents it. It is accepted in the cycle after Busy falls, which is the Done cycle.
- ReadHiLo while Busy: Stall is asserted. HI/LO keep their old values until the FIX write.
- Start and ReadHiLo in the same IDLE cycle: no stall. The read sees the pre-write HI/LO.

Decomposition:
- Shared package muldiv_pkg holds:
  - the 3-bit Op encodings (OP_NONE … OP_MTLO);
  - the state encodings IDLE/RUN/FIX;
  - localparam DATA_WIDTH = 32.
- One natural sub-module: muldiv_datapath. It holds the combined 2*DATA_WIDTH accumulator/remainder shift register and the add/subtract step. The top module keeps the FSM, counter, sign handling and HI/LO registers.

Test Plan:
- MULT with A = 0xFFFFFFFE (-2), B = 3 -> Busy for 33 cycles, then Done pulse with HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- MULTU with A = 0xFFFFFFFF, B = 2 -> HI = 0x00000001, LO = 0xFFFFFFFE. Then DIV with A = 0xFFFFFFF9 (-7), B = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU with A = 7, B = 0 -> after 33 busy cycles, Done and DivByZero pulse together, LO = 0xFFFFFFFF, HI = 0x00000007.
- MTHI with A = 0x1234, then MTLO with A = 0x5678 -> HI/LO update on the sampling edge, Busy and Done stay 0. Then MULT with A = 4, B = 2 while ReadHiLo is held -> Stall = 1 for the whole busy window. HI/LO read 0x1234/0x5678 until the Done cycle, then 0/8.
- Start a second MULT five cycles into a DIV with A = 100, B = 7 -> Stall = 1 and the second request is ignored. The DIV completes with LO = 14, HI = 2. Re-asserting Start in the Done cycle starts the MULT.
- Assert Reset at cycle 10 of a MULT -> HI = LO = 0 and Busy = 0 immediately. No Done pulse. A following MULTU with A = 3, B = 5 gives LO = 15.
